// File: rtl/vga_timing_gen.sv
// Purpose : free-running VGA raster timing (position, blank, syncs, line/frame strobes, frame counter).
// Latency : every output is a registered decode of the current raster counters (one cycle).
// Backpr. : none; the raster advances every pixel clock unconditionally.
//
// Ports:
//   vga_clk      pixel clock, all logic on the rising edge
//   reset_n      asynchronous active-low reset
//   DrawX/DrawY  current pixel position (0..H_TOTAL-1 / 0..V_TOTAL-1)
//   blank        1 while the pixel is inside the visible area
//   hs/vs        active-low horizontal / vertical sync
//   line_start   one-cycle pulse on DrawX==0
//   frame_start  one-cycle pulse on DrawX==0 && DrawY==0
//   frame_count  frames started since reset, modulo 256
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    // All decode thresholds are held as 10-bit constants so every compare is
    // an unsigned 10-bit compare against the counters.
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] H_SYNC_S = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_E = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] V_SYNC_S = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_E = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    logic [9:0] drawx_q, drawy_q;
    logic       blank_q, blank_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       ls_q, ls_d;
    logic       fs_q, fs_d;
    logic [7:0] fcnt_q, fcnt_d;

    // Raster counters: vc only moves on the hc wrap, so (H_LAST,V_LAST) -> (0,0).
    always_comb begin
        hc_d = hc_q + 10'd1;
        vc_d = vc_q;
        if (hc_q == H_LAST) begin
            hc_d = '0;
            vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
        end
    end

    // Output decodes of the current counters; registered below so position,
    // blank and syncs all describe the same pixel.
    always_comb begin
        blank_d = (hc_q < H_VIS) && (vc_q < V_VIS);
        hs_d    = !((hc_q >= H_SYNC_S) && (hc_q < H_SYNC_E));
        vs_d    = !((vc_q >= V_SYNC_S) && (vc_q < V_SYNC_E));
        ls_d    = (hc_q == '0);
        fs_d    = (hc_q == '0) && (vc_q == '0);
        // Counter steps in the same cycle the frame strobe is presented, so the
        // first pixel after reset already reads frame_count==1.
        fcnt_d  = fs_d ? fcnt_q + 8'd1 : fcnt_q;
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hc_q    <= '0;
            vc_q    <= '0;
            drawx_q <= '0;
            drawy_q <= '0;
            blank_q <= 1'b0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            drawx_q <= hc_q;
            drawy_q <= vc_q;
            blank_q <= blank_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign DrawX       = drawx_q;
    assign DrawY       = drawy_q;
    assign blank       = blank_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign frame_count = fcnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Purpose : scoreboard bench for vga_timing_gen: a full-size 640x480 instance and a tiny-raster instance.
// Latency : expectations are queued right after each rising edge and checked on the following falling edge.
// Backpr. : none; the design outputs a new pixel every cycle, so one expectation per DUT per cycle.
module tb_vga_timing_gen;

    // Index 0 = full-size instance, index 1 = tiny raster (15x8) used for the
    // vertical, frame-wrap and 256-frame checks within a short run.
    localparam int HA [2] = '{640, 8};
    localparam int HF [2] = '{16, 2};
    localparam int HS [2] = '{96, 3};
    localparam int HB [2] = '{48, 2};
    localparam int VA [2] = '{480, 4};
    localparam int VF [2] = '{10, 1};
    localparam int VS [2] = '{2, 2};
    localparam int VB [2] = '{33, 1};

    localparam int F_X = 0, F_Y = 1, F_BLANK = 2, F_HS = 3, F_VS = 4, F_LS = 5, F_FS = 6, F_FC = 7;

    typedef struct {
        int x; int y; int blank; int hs; int vs; int ls; int fs; int fc;
    } obs_t;

    typedef struct {
        int   sel;
        obs_t o;
    } exp_t;

    typedef struct {
        int    ph;
        int    sel;
        int    n;
        int    fld;
        int    val;
        string tag;
    } dv_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;

    logic [9:0] bx, by, sx, sy;
    logic       bblank, bhs, bvs, bls, bfs;
    logic       sblank, shs, svs, sls, sfs;
    logic [7:0] bfc, sfc;

    exp_t exp_q[$];
    dv_t  dir_q[$];
    dv_t  dv_tab[$];

    int cmp_cnt = 0;
    int err_cnt = 0;
    int n = 0;
    int phase = 0;

    vga_timing_gen u_big (
        .vga_clk(clk), .reset_n(rst_n),
        .DrawX(bx), .DrawY(by), .blank(bblank), .hs(bhs), .vs(bvs),
        .line_start(bls), .frame_start(bfs), .frame_count(bfc)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) u_small (
        .vga_clk(clk), .reset_n(rst_n),
        .DrawX(sx), .DrawY(sy), .blank(sblank), .hs(shs), .vs(svs),
        .line_start(sls), .frame_start(sfs), .frame_count(sfc)
    );

    always #5 clk = ~clk;

    function automatic obs_t sample(input int sel);
        obs_t o;
        if (sel == 0) begin
            o.x = int'(bx); o.y = int'(by); o.blank = int'(bblank); o.hs = int'(bhs);
            o.vs = int'(bvs); o.ls = int'(bls); o.fs = int'(bfs); o.fc = int'(bfc);
        end else begin
            o.x = int'(sx); o.y = int'(sy); o.blank = int'(sblank); o.hs = int'(shs);
            o.vs = int'(svs); o.ls = int'(sls); o.fs = int'(sfs); o.fc = int'(sfc);
        end
        return o;
    endfunction

    function automatic int pick(input obs_t o, input int fld);
        case (fld)
            F_X:     return o.x;
            F_Y:     return o.y;
            F_BLANK: return o.blank;
            F_HS:    return o.hs;
            F_VS:    return o.vs;
            F_LS:    return o.ls;
            F_FS:    return o.fs;
            default: return o.fc;
        endcase
    endfunction

    // Reference: edge k after release shows raster pixel k-1 in row-major order.
    function automatic obs_t model(input int sel, input int k);
        obs_t o;
        int ht, vt, p, x, y;
        if (k == 0) begin
            o.x = 0; o.y = 0; o.blank = 0; o.hs = 1; o.vs = 1; o.ls = 0; o.fs = 0; o.fc = 0;
            return o;
        end
        ht = HA[sel] + HF[sel] + HS[sel] + HB[sel];
        vt = VA[sel] + VF[sel] + VS[sel] + VB[sel];
        p  = k - 1;
        x  = p % ht;
        y  = (p / ht) % vt;
        o.x     = x;
        o.y     = y;
        o.blank = (x < HA[sel] && y < VA[sel]) ? 1 : 0;
        o.hs    = (x >= HA[sel] + HF[sel] && x < HA[sel] + HF[sel] + HS[sel]) ? 0 : 1;
        o.vs    = (y >= VA[sel] + VF[sel] && y < VA[sel] + VF[sel] + VS[sel]) ? 0 : 1;
        o.ls    = (x == 0) ? 1 : 0;
        o.fs    = (x == 0 && y == 0) ? 1 : 0;
        o.fc    = ((p / (ht * vt)) + 1) % 256;
        return o;
    endfunction

    task automatic chk(input string nm, input int act, input int expv);
        cmp_cnt++;
        if (act != expv) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic add_dv(input int ph, input int sel, input int k, input int fld, input int val, input string tag);
        dv_t d;
        d.ph = ph; d.sel = sel; d.n = k; d.fld = fld; d.val = val; d.tag = tag;
        dv_tab.push_back(d);
    endtask

    // One pixel clock: after the rising edge, apply the reset level for this
    // cycle and queue what both DUTs must show until the next rising edge.
    task automatic cyc(input logic rst_val);
        exp_t e;
        @(posedge clk);
        #1;
        if (rst_n) n++;
        rst_n = rst_val;
        if (!rst_n) n = 0;
        for (int s = 0; s < 2; s++) begin
            e.sel = s;
            e.o   = model(s, n);
            exp_q.push_back(e);
        end
        if (n > 0) begin
            foreach (dv_tab[i]) begin
                if (dv_tab[i].ph == phase && dv_tab[i].n == n) dir_q.push_back(dv_tab[i]);
            end
        end
    endtask

    // Monitor: the DUTs present a pixel every cycle; drain whatever is queued.
    initial begin
        exp_t e;
        dv_t  d;
        obs_t o;
        string pre;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                o   = sample(e.sel);
                pre = (e.sel == 0) ? "big" : "small";
                chk({pre, ".DrawX"},       o.x,     e.o.x);
                chk({pre, ".DrawY"},       o.y,     e.o.y);
                chk({pre, ".blank"},       o.blank, e.o.blank);
                chk({pre, ".hs"},          o.hs,    e.o.hs);
                chk({pre, ".vs"},          o.vs,    e.o.vs);
                chk({pre, ".line_start"},  o.ls,    e.o.ls);
                chk({pre, ".frame_start"}, o.fs,    e.o.fs);
                chk({pre, ".frame_count"}, o.fc,    e.o.fc);
            end
            while (dir_q.size() > 0) begin
                d = dir_q.pop_front();
                chk({"dir ", d.tag}, pick(sample(d.sel), d.fld), d.val);
            end
        end
    end

    initial begin
        // Hand-computed points. Full-size raster, first line after release.
        add_dv(0, 0, 1,   F_FS,    1,   "big e1 frame_start");
        add_dv(0, 0, 1,   F_BLANK, 1,   "big e1 blank");
        add_dv(0, 0, 1,   F_FC,    1,   "big e1 frame_count");
        add_dv(0, 0, 640, F_BLANK, 1,   "big e640 blank");
        add_dv(0, 0, 641, F_X,     640, "big e641 DrawX");
        add_dv(0, 0, 641, F_BLANK, 0,   "big e641 blank");
        add_dv(0, 0, 656, F_HS,    1,   "big e656 hs");
        add_dv(0, 0, 657, F_HS,    0,   "big e657 hs");
        add_dv(0, 0, 752, F_HS,    0,   "big e752 hs");
        add_dv(0, 0, 753, F_HS,    1,   "big e753 hs");
        add_dv(0, 0, 801, F_X,     0,   "big e801 DrawX");
        add_dv(0, 0, 801, F_Y,     1,   "big e801 DrawY");
        add_dv(0, 0, 801, F_LS,    1,   "big e801 line_start");
        add_dv(0, 0, 801, F_FS,    0,   "big e801 frame_start");
        // Tiny raster: 15 px/line, 8 lines, vs low on lines 5..6, blank off from line 4.
        add_dv(0, 1, 61,  F_BLANK, 0,   "small line4 blank");
        add_dv(0, 1, 75,  F_VS,    1,   "small y4 x14 vs");
        add_dv(0, 1, 76,  F_VS,    0,   "small y5 x0 vs");
        add_dv(0, 1, 105, F_VS,    0,   "small y6 x14 vs");
        add_dv(0, 1, 106, F_VS,    1,   "small y7 x0 vs");
        add_dv(0, 1, 120, F_X,     14,  "small last px DrawX");
        add_dv(0, 1, 120, F_Y,     7,   "small last px DrawY");
        add_dv(0, 1, 121, F_X,     0,   "small wrap DrawX");
        add_dv(0, 1, 121, F_Y,     0,   "small wrap DrawY");
        add_dv(0, 1, 121, F_FS,    1,   "small wrap frame_start");
        add_dv(0, 1, 121, F_FC,    2,   "small wrap frame_count");
        // Mid-frame point just before the asynchronous reset.
        add_dv(1, 1, 276, F_X,     5,   "small midframe DrawX");
        add_dv(1, 1, 276, F_Y,     2,   "small midframe DrawY");
        add_dv(1, 1, 276, F_FC,    3,   "small midframe frame_count");
        // After reset release, then frame_count wrap on the 256th frame.
        add_dv(2, 1, 1,     F_FC,  1,   "small restart frame_count");
        add_dv(2, 1, 1,     F_FS,  1,   "small restart frame_start");
        add_dv(2, 1, 30481, F_FC,  255, "small frame255 frame_count");
        add_dv(2, 1, 30600, F_FC,  255, "small pre-wrap frame_count");
        add_dv(2, 1, 30601, F_FC,  0,   "small wrap frame_count");
        add_dv(2, 1, 30601, F_FS,  1,   "small wrap256 frame_start");
        add_dv(2, 1, 30601, F_X,   0,   "small wrap256 DrawX");

        #2 rst_n = 1'b0;
        repeat (5) cyc(1'b0);
        phase = 0;
        cyc(1'b1);
        repeat (1700) cyc(1'b1);

        repeat (3) cyc(1'b0);
        phase = 1;
        cyc(1'b1);
        repeat (276) cyc(1'b1);
        // Reset lands 1 time unit after an edge; the next falling-edge sample
        // must already show reset values.
        cyc(1'b0);
        repeat (2) cyc(1'b0);

        phase = 2;
        cyc(1'b1);
        repeat (30610) cyc(1'b1);

        @(negedge clk);
        #1;
        chk("scoreboard drained", exp_q.size() + dir_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480 @ 60 Hz VGA raster timing from the 25 MHz pixel clock. It drives `DrawX`, `DrawY` and `blank` into the sprite/ROM renderers, and `hs`/`vs` to the DAC/connector. It sits upstream of every pixel-color module, which index sprite ROMs from `DrawX`/`DrawY` and gate color with `blank`. It also emits per-line and per-frame strobes plus a free-running frame counter for sprite animation and game-state updates.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)

Ports:
- `vga_clk`  in  1  pixel clock (25 MHz); the only clock; all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `DrawX`  out  10  horizontal pixel index of current pixel, 0..H_TOTAL-1
- `DrawY`  out  10  vertical line index of current pixel, 0..V_TOTAL-1
- `blank`  out  1  1 = pixel is in visible area (color may be driven), 0 = blanking
- `hs`  out  1  horizontal sync, active-low
- `vs`  out  1  vertical sync, active-low
- `line_start`  out  1  one-cycle pulse on the pixel with DrawX==0
- `frame_start`  out  1  one-cycle pulse on the pixel with DrawX==0 and DrawY==0
- `frame_count`  out  8  frames started since reset, modulo 256

## Operation
- Derived totals: `H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP` (800); `V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP` (525).
- Internal counters `hc` (0..H_TOTAL-1) and `vc` (0..V_TOTAL-1), 10 bits each.
- Counter stepping:
  - `hc` increments every cycle and wraps from H_TOTAL-1 to 0.
  - On that wrap, `vc` increments, and wraps from V_TOTAL-1 to 0.
  - The simultaneous hc and vc wrap at (799,524) goes to (0,0).
- Each cycle, all outputs are registered decodes of the current (`hc`,`vc`):
  - `DrawX<=hc`, `DrawY<=vc`.
  - `blank<=(hc<H_ACTIVE)&&(vc<V_ACTIVE)`.
  - `hs<=!(hc>=H_ACTIVE+H_FP && hc<H_ACTIVE+H_FP+H_SYNC)`, i.e. low for hc 656..751.
  - `vs<=!(vc>=V_ACTIVE+V_FP && vc<V_ACTIVE+V_FP+V_SYNC)`, i.e. low for vc 490..491.
  - `line_start<=(hc==0)`, `frame_start<=(hc==0&&vc==0)`.
- `frame_count` increments in the same cycle `frame_start` is driven high. It wraps 255->0 with no flag.
- All outputs describe the same pixel in the same cycle; no skew between position, `blank` and syncs.
- `vs` transitions are aligned to line boundaries (hc==0), not to hsync.
- Arithmetic is unsigned, 10-bit. Parameter sums must fit in 10 bits (totals <= 1023); this is not checked in hardware.

## Timing
- Reset values (asynchronous, held while `reset_n`=0):
  - `hc`=0, `vc`=0.
  - `DrawX`=0, `DrawY`=0, `blank`=0, `hs`=1, `vs`=1.
  - `line_start`=0, `frame_start`=0, `frame_count`=0.
- Output latency: one cycle from counters to outputs.
  - First rising edge after `reset_n` deassertion presents pixel (0,0): `blank`=1, `line_start`=1, `frame_start`=1, `frame_count`=1.
  - The k-th edge after release presents raster pixel k-1 (row-major, 800 per line).
- Periods: line = 800 cycles; frame = 420000 cycles; `frame_start` period 420000 cycles exactly.
- Reset asserted mid-frame: outputs go to reset values immediately (async). On release, the sequence restarts from pixel (0,0) as above; no partial frame resumes.
- Downstream renderers read ROM on the falling edge and register color on the next rising edge. The one-cycle color lag this creates belongs to the consumer; this block applies no compensation.

## Test plan
- Reset: hold `reset_n`=0 for 5 cycles -> `DrawX`=0, `DrawY`=0, `blank`=0, `hs`=1, `vs`=1, `frame_count`=0, both strobes 0.
- First line: release reset, count edges:
  - edge 1: `frame_start`=1, `blank`=1.
  - edge 641 (DrawX=640): `blank`=0.
  - `hs` low from edge 657 (DrawX=656) to edge 752 (DrawX=751), high at edge 753.
  - edge 801: `DrawX`=0, `DrawY`=1, `line_start`=1, `frame_start`=0.
- Vertical: `vs`=0 exactly while DrawY in 490..491 (1600 cycles). `blank`=0 for all DrawY>=480.
- Frame wrap: after DrawX=799, DrawY=524, next cycle -> DrawX=0, DrawY=0, `frame_start`=1. Consecutive `frame_start` pulses are 420000 cycles apart.
- Reset mid-frame: assert `reset_n`=0 at DrawX=300, DrawY=200, `frame_count`=3 -> outputs reset immediately. After release, edge 1 shows (0,0) with `frame_count`=1.
- Counter wrap: run 256 frames -> `frame_count` steps 255->0 on the 256th `frame_start`, with timing unaffected.
